// File: rtl/nanov_spi_fetch.sv
// nanoV instruction fetch: SPI READ (0x03) master that streams 32-bit little-endian
// words into a one-word holding register with valid/ready back-pressure.
module nanov_spi_fetch #(
    parameter int unsigned ADDR_BITS = 24
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] start_addr,
    input  logic                 stop,
    output logic [31:0]          instr,
    output logic [ADDR_BITS-1:0] instr_addr,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic                 busy,
    output logic                 spi_cs_n,
    output logic                 spi_clk,
    output logic                 spi_mosi,
    input  logic                 spi_miso
);
    localparam int unsigned TX_BITS = 8 + ADDR_BITS;
    localparam int unsigned CNT_W   = $clog2((ADDR_BITS > 32 ? ADDR_BITS : 32) + 1);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, STALL, GAP} state_t;

    state_t               state_q, state_d;
    logic                 phase_q, phase_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [TX_BITS-1:0]   tx_q, tx_d;
    logic [31:0]          rx_q, rx_d;
    logic [ADDR_BITS-1:0] fetch_q, fetch_d;
    logic [31:0]          instr_d;
    logic [ADDR_BITS-1:0] iaddr_d;
    logic                 valid_d;
    logic [31:0]          rx_shift;
    logic                 hs;

    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    assign rx_shift = {rx_q[30:0], spi_miso};
    assign hs       = instr_valid && instr_ready;

    assign busy     = (state_q == CMD) || (state_q == ADDR) || (state_q == DATA) || (state_q == STALL);
    assign spi_cs_n = !busy;
    assign spi_clk  = phase_q && ((state_q == CMD) || (state_q == ADDR) || (state_q == DATA));
    assign spi_mosi = ((state_q == CMD) || (state_q == ADDR)) && tx_q[TX_BITS-1];

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        fetch_d = fetch_q;
        instr_d = instr;
        iaddr_d = instr_addr;
        valid_d = instr_valid;
        if (hs) valid_d = 1'b0;

        if (start) begin
            // A restart from an open transaction first parks CS high for two cycles (GAP).
            tx_d    = {8'h03, start_addr & ~ADDR_BITS'(3)};
            fetch_d = start_addr & ~ADDR_BITS'(3);
            phase_d = 1'b0;
            cnt_d   = '0;
            rx_d    = '0;
            valid_d = 1'b0;
            state_d = (state_q == IDLE) ? CMD : GAP;
        end else if (stop) begin
            state_d = IDLE;
            phase_d = 1'b0;
            cnt_d   = '0;
            rx_d    = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                GAP: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = CMD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                CMD, ADDR, DATA: begin
                    phase_d = !phase_q;
                    if (phase_q) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (state_q == DATA) rx_d = rx_shift;
                        else                 tx_d = tx_q << 1;
                        if (state_q == CMD && cnt_q == CNT_W'(7)) begin
                            state_d = ADDR;
                            cnt_d   = '0;
                        end else if (state_q == ADDR && cnt_q == CNT_W'(ADDR_BITS - 1)) begin
                            state_d = DATA;
                            cnt_d   = '0;
                        end else if (state_q == DATA && cnt_q == CNT_W'(31)) begin
                            cnt_d = '0;
                            if (!instr_valid || hs) begin
                                instr_d = byte_swap(rx_shift);
                                iaddr_d = fetch_q;
                                fetch_d = fetch_q + ADDR_BITS'(4);
                                valid_d = 1'b1;
                            end else begin
                                state_d = STALL;
                            end
                        end
                    end
                end
                STALL: begin
                    // Completed word waits in rx_q until the holding register is taken.
                    if (hs) begin
                        instr_d = byte_swap(rx_q);
                        iaddr_d = fetch_q;
                        fetch_d = fetch_q + ADDR_BITS'(4);
                        valid_d = 1'b1;
                        state_d = DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            phase_q     <= 1'b0;
            cnt_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            fetch_q     <= '0;
            instr       <= '0;
            instr_addr  <= '0;
            instr_valid <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            fetch_q     <= fetch_d;
            instr       <= instr_d;
            instr_addr  <= iaddr_d;
            instr_valid <= valid_d;
        end
    end
endmodule

// File: doc/nanov_spi_fetch.md
# nanov_spi_fetch

Instruction fetch unit for nanoV: an SPI master that streams 32-bit instruction words out of an external SPI flash/RAM using the standard READ command 0x03 and hands them to the core over a valid/ready handshake. It sits between the core's `instr` input and the memory pins. It supports sequential streaming, back-pressure by pausing SCK, and restart at a new address for jumps.

## Interface
- `ADDR_BITS`, 24: width of the memory byte address sent after the command.
- `clk`  in  1  system clock.
- `rstn`  in  1  reset; synchronous, active-low. Clock is `clk`.
- `start`  in  1  one-cycle request to begin (or restart) fetching at `start_addr`.
- `start_addr`  in  ADDR_BITS  byte address of the first word. Bits [1:0] are ignored and treated as 0.
- `stop`  in  1  abort fetching, release the bus.
- `instr`  out  32  current instruction word, little-endian.
- `instr_addr`  out  ADDR_BITS  byte address of `instr`.
- `instr_valid`  out  1  `instr` and `instr_addr` are valid.
- `instr_ready`  in  1  consumer accepts the word when `instr_valid && instr_ready`.
- `busy`  out  1  a transaction is open (`spi_cs_n` low).
- `spi_cs_n`  out  1  chip select, active low.
- `spi_clk`  out  1  SPI SCK, mode 0.
- `spi_mosi`  out  1  serial data to memory.
- `spi_miso`  in  1  serial data from memory.

## Operation
- **States:**
  - IDLE.
  - CMD: 8 bits, 0x03, MSB first.
  - ADDR: ADDR_BITS bits, MSB first.
  - DATA: repeating 32-bit words.
  - STALL: SCK parked low, CS held low.
- **Transitions:**
  - IDLE→CMD on `start`.
  - CMD→ADDR after bit 7.
  - ADDR→DATA after the last address bit.
  - DATA→STALL when a word completes and the holding register is still full and not being taken this cycle.
  - STALL→DATA on the handshake.
  - Any state→IDLE on `stop`.
- **Bit timing:** each SPI bit takes two clk cycles.
  - Phase L: `spi_clk`=0. `spi_mosi` is updated at the start of phase L.
  - Phase H: `spi_clk`=1.
  - `spi_miso` is sampled on the clk edge that ends phase H.
- **Byte order:** the first received byte goes to `instr[7:0]`, the second to [15:8], and so on. Within a byte, the first bit received is the MSB.
- `spi_mosi` is 0 during DATA and IDLE.
- **Buffering:** a 32-bit shift register feeds a one-word holding register (`instr`).
  - On word completion, if the holding register is empty or handshaking this cycle, the word loads and `instr_valid`=1.
  - Otherwise the block enters STALL.
  - On a handshake with no new word ready, `instr_valid` drops the next cycle.
- **Addressing:** `instr_addr` = `start_addr` for the first word, then +4 per word, wrapping modulo 2^ADDR_BITS.
- **`start` while busy:** treated as a jump. The current transaction is aborted, `instr_valid` clears, `spi_cs_n` goes high for exactly 2 cycles, then a new CMD phase begins.
- **`start` and `stop` in the same cycle:** `start` wins.
- **`stop`:** clears `instr_valid`, drives `spi_cs_n`=1 and `spi_clk`=0 the next cycle, and discards any partial word.
- **Handshake ownership:** the handshake is honoured only when `instr_valid`=1. `instr_ready` is otherwise ignored.

## Timing
- **Reset values:**
  - `spi_cs_n`=1.
  - `spi_clk`=0, `spi_mosi`=0.
  - `instr`=0, `instr_addr`=0.
  - `instr_valid`=0, `busy`=0.
  - State IDLE.
- **Reset mid-transaction:** reset returns all outputs to these values on the next edge.
- **Start from IDLE:** with `start` sampled at edge E0, `spi_cs_n`=0 and `busy`=1 from E0. The first CMD bit is on `spi_mosi` from E0.
- **First word latency:** `instr_valid` rises at edge E0 + 2·(8+ADDR_BITS+32), which is E0+128 for the default.
- **Streaming:** with `instr_ready` held high, there is one new word every 64 cycles with no SCK gaps.
- **STALL:** `spi_clk` stays 0. After the handshake, SCK resumes with phase L on the next cycle.
- **Hold during wait:** `instr` and `instr_addr` are stable while `instr_valid && !instr_ready`.

## Test plan
- **Reset:** assert `rstn`=0 mid-DATA → next cycle `spi_cs_n`=1, `spi_clk`=0, `instr_valid`=0, `instr`=0.
- **Command/address and first word:**
  - Stimulus: `start` with `start_addr`=0x000104; memory model returns bytes 13 05 00 00.
  - Required: MOSI carries 0x03 then 0x000104 (MSB first); `instr_valid` at E0+128; `instr`=0x00000513; `instr_addr`=0x000104.
- **Streaming with ready held high:**
  - Stimulus: memory returns three words.
  - Required: valid words at E0+128, +192, +256; addresses 0x104, 0x108, 0x10C; `spi_clk` toggles continuously.
- **Back-pressure:**
  - Stimulus: `instr_ready`=0 for 200 cycles after the first word.
  - Required: the second word completes, then `spi_clk` is held 0 with `spi_cs_n`=0 and `instr` unchanged. On ready, the second word appears the next cycle and SCK resumes.
- **Jump:**
  - Stimulus: `start` with 0x000200 during DATA.
  - Required: `instr_valid` clears; `spi_cs_n` is high for 2 cycles; a new 0x03/0x000200 sequence; the first word is tagged 0x000200.
- **Wrap and stop:**
  - Stimulus: `start_addr`=0xFFFFFC with two words accepted.
  - Required: second `instr_addr`=0x000000. `stop` then gives `spi_cs_n`=1, `busy`=0, `instr_valid`=0 next cycle.
